// File: rtl/cnn_param_loader_if.sv
// cnn_param_loader_if: host word stream and RAM write port of the parameter loader
interface cnn_param_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  modport master (output in_valid, in_data, input in_ready, ram_we, ram_addr, ram_wdata);
  modport slave (input in_valid, in_data, output in_ready, ram_we, ram_addr, ram_wdata);
endinterface

// File: rtl/cnn_param_loader.sv
// cnn_param_loader: builds the CNN parameter RAM image from a host stream; PAYLOAD_CHECKSUM_EN adds a payload checksum port
module cnn_param_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int MAX_LAYERS = 10
) (
  input  logic clk,
  input  logic RST,
  input  logic start,
  cnn_param_loader_if.slave bus,
  output logic busy,
  output logic done,
  output logic err,
  output logic [ADDR_W-1:0] filter_offset,
  output logic [ADDR_W-1:0] dense_offset
`ifdef PAYLOAD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);
  // accumulators are wide enough that n*FS*FS never wraps before the range check
  localparam int ACC_W = 3 * DATA_W + ADDR_W + 8;
  typedef enum logic [3:0] {
    IDLE, HDR_FS, HDR_NL, HDR_FCNT, HDR_FTYPE, HDR_DENSE, WR_FOFF, WR_DOFF, PAYLOAD, DONE, ERR
  } state_t;
  state_t state, stateNext;
  logic [DATA_W-1:0] fs, numL;
  logic [ADDR_W-1:0] cnt, idx, nl, foNew, wrAddr;
  logic [DATA_W-1:0] wrData;
  logic [ACC_W-1:0] acc, dsum, remaining, doFull, remFull, endFull;
  logic take, lastCnt, badL, ovf, wrEn, restart;
  assign bus.in_ready = state inside {HDR_FS, HDR_NL, HDR_FCNT, HDR_FTYPE, HDR_DENSE, PAYLOAD};
  assign take = bus.in_valid & bus.in_ready;
  assign busy = !(state inside {IDLE, DONE, ERR});
  assign done = state == DONE;
  assign err = state == ERR;
  assign restart = start & !busy;
  assign nl = ADDR_W'(numL);
  assign badL = bus.in_data == '0 || bus.in_data > DATA_W'(MAX_LAYERS);
  assign foNew = (ADDR_W'(bus.in_data) << 2) + ADDR_W'(2);
  assign lastCnt = state == HDR_DENSE ? cnt == (nl << 1) - ADDR_W'(3) : cnt == nl - ADDR_W'(1);
  assign doFull = ACC_W'(filter_offset) + acc;
  assign remFull = acc + dsum;
  assign endFull = ACC_W'(filter_offset) + remFull;
  assign ovf = (|doFull[ACC_W-1:ADDR_W]) | (|endFull[ACC_W-1:ADDR_W]);
  // state register
  always_ff @(posedge clk or negedge RST)
    if (!RST) state <= IDLE;
    else state <= stateNext;
  // next state and the RAM write request for this cycle
  always_comb begin
    stateNext = state;
    wrEn = 1'b0;
    wrAddr = '0;
    wrData = bus.in_data;
    case (state)
      IDLE: stateNext = start ? HDR_FS : IDLE;
      HDR_FS: if (take) begin
        wrEn = 1'b1;
        stateNext = HDR_NL;
      end
      HDR_NL: if (take) begin
        wrEn = !badL;
        wrAddr = ADDR_W'(1);
        stateNext = badL ? ERR : HDR_FCNT;
      end
      HDR_FCNT: if (take) begin
        wrEn = 1'b1;
        wrAddr = ADDR_W'(4) + cnt;
        stateNext = lastCnt ? HDR_FTYPE : HDR_FCNT;
      end
      HDR_FTYPE: if (take) begin
        wrEn = 1'b1;
        wrAddr = ADDR_W'(4) + nl + cnt;
        stateNext = !lastCnt ? HDR_FTYPE : numL == DATA_W'(1) ? WR_FOFF : HDR_DENSE;
      end
      HDR_DENSE: if (take) begin
        wrEn = 1'b1;
        wrAddr = ADDR_W'(4) + (nl << 1) + cnt;
        stateNext = lastCnt ? WR_FOFF : HDR_DENSE;
      end
      WR_FOFF: begin
        wrEn = 1'b1;
        wrAddr = ADDR_W'(2);
        wrData = DATA_W'(filter_offset);
        stateNext = WR_DOFF;
      end
      WR_DOFF: begin
        wrEn = 1'b1;
        wrAddr = ADDR_W'(3);
        wrData = DATA_W'(doFull);
        stateNext = ovf ? ERR : remFull == '0 ? DONE : PAYLOAD;
      end
      PAYLOAD: if (take) begin
        wrEn = 1'b1;
        wrAddr = filter_offset + idx;
        stateNext = ACC_W'(idx) + ACC_W'(1) == remaining ? DONE : PAYLOAD;
      end
      DONE, ERR: stateNext = start ? HDR_FS : state;
      default: stateNext = IDLE;
    endcase
  end
  // header fields, counters and offset arithmetic; cleared by a restart
  always_ff @(posedge clk or negedge RST)
    if (!RST || restart) begin
      fs <= '0;
      numL <= '0;
      cnt <= '0;
      idx <= '0;
      acc <= '0;
      dsum <= '0;
      remaining <= '0;
      filter_offset <= '0;
      dense_offset <= '0;
    end else begin
      if (take && state == HDR_FS) fs <= bus.in_data;
      if (take && state == HDR_NL && !badL) begin
        numL <= bus.in_data;
        filter_offset <= foNew;
      end
      if (take && state inside {HDR_FCNT, HDR_FTYPE, HDR_DENSE}) cnt <= lastCnt ? '0 : cnt + ADDR_W'(1);
      if (take && state == HDR_FCNT) acc <= acc + ACC_W'(bus.in_data) + ACC_W'(bus.in_data) * ACC_W'(fs) * ACC_W'(fs);
      if (take && state == HDR_DENSE) dsum <= dsum + ACC_W'(bus.in_data);
      if (state == WR_DOFF) begin
        dense_offset <= ADDR_W'(doFull);
        remaining <= remFull;
      end
      if (take && state == PAYLOAD) idx <= idx + ADDR_W'(1);
    end
  // registered RAM write port, one strobe per word
  always_ff @(posedge clk or negedge RST)
    if (!RST) begin
      bus.ram_we <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_wdata <= '0;
    end else begin
      bus.ram_we <= wrEn;
      if (wrEn) begin
        bus.ram_addr <= wrAddr;
        bus.ram_wdata <= wrData;
      end
    end
`ifdef PAYLOAD_CHECKSUM_EN
  // running modular sum of accepted payload words
  always_ff @(posedge clk or negedge RST)
    if (!RST || restart) checksum <= '0;
    else if (take && state == PAYLOAD) checksum <= checksum + bus.in_data;
`endif
endmodule

// File: tb/tb_cnn_param_loader.sv
// tb_cnn_param_loader: randomized self-checking bench for cnn_param_loader against an image model
module tb_cnn_param_loader;
  logic clk = 1'b0;
  logic RST = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;
  logic [15:0] filter_offset, dense_offset;
`ifdef PAYLOAD_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  int nCmp = 0;
  int nBad = 0;
  int nWrites = 0;
  int gap = 0;
  int mem[int];
  int nomC[$], nomT[$], nomD[$], nomP[$];
  cnn_param_loader_if bus();
  cnn_param_loader dut (
    .clk(clk),
    .RST(RST),
    .start(start),
    .bus(bus),
    .busy(busy),
    .done(done),
    .err(err),
    .filter_offset(filter_offset),
    .dense_offset(dense_offset)
`ifdef PAYLOAD_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );
  always #5 clk = ~clk;
  // record every RAM write and count busy cycles with no word acceptance possible
  always @(negedge clk) begin
    if (bus.ram_we) begin
      mem[int'(bus.ram_addr)] = int'(bus.ram_wdata);
      nWrites++;
    end
    if (busy && !bus.in_ready) gap++;
  end
  task automatic check(input string tag, input longint got, input longint exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic sendWords(input int w[$], input int n, input int mode);
    int i = 0;
    int guard = 0;
    bit tog = 1'b1;
    while (i < n && guard < 5000) begin
      @(negedge clk);
      bus.in_valid = mode == 0 ? 1'b1 : mode == 1 ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      bus.in_data = bus.in_valid ? 16'(w[i]) : 16'($urandom);
      #1;
      if (bus.in_valid && bus.in_ready) i++;
      guard++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("wordsAccepted", i, n);
  endtask
  task automatic waitEnd();
    int k = 0;
    while (!(done || err) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("finished", done || err, 1);
    repeat (2) @(negedge clk);
  endtask
  task automatic checkLoad(input int fs, input int nl, input int c[$], input int t[$], input int d[$], input int p[$]);
    int expMem[int];
    int fo, acc, dsum, a, sum;
    fo = 2 + 4 * nl;
    acc = 0;
    dsum = 0;
    sum = 0;
    expMem[0] = fs;
    expMem[1] = nl;
    expMem[2] = fo;
    a = 4;
    foreach (c[i]) begin
      expMem[a++] = c[i];
      acc += c[i] * (1 + fs * fs);
    end
    foreach (t[i]) expMem[a++] = t[i];
    foreach (d[i]) begin
      expMem[a++] = d[i];
      dsum += d[i];
    end
    expMem[3] = fo + acc;
    foreach (p[i]) begin
      expMem[fo + i] = p[i];
      sum = (sum + p[i]) % 65536;
    end
    check("writeCount", nWrites, expMem.num());
    foreach (expMem[k]) check($sformatf("mem[%0d]", k), mem.exists(k) ? mem[k] : -1, expMem[k]);
    check("done", done, 1);
    check("err", err, 0);
    check("busy", busy, 0);
    check("filterOffset", filter_offset, fo);
    check("denseOffset", dense_offset, fo + acc);
    check("readyGap", gap, 2);
`ifdef PAYLOAD_CHECKSUM_EN
    check("checksum", checksum, sum);
`endif
  endtask
  task automatic runLoad(input int fs, input int nl, input int c[$], input int t[$], input int d[$], input int p[$], input int mode);
    int w[$];
    w = {fs, nl};
    foreach (c[i]) w.push_back(c[i]);
    foreach (t[i]) w.push_back(t[i]);
    foreach (d[i]) w.push_back(d[i]);
    foreach (p[i]) w.push_back(p[i]);
    mem.delete();
    nWrites = 0;
    gap = 0;
    pulseStart();
    sendWords(w, w.size(), mode);
    waitEnd();
    checkLoad(fs, nl, c, t, d, p);
  endtask
  task automatic runBad(input int fs, input int nl);
    int w[$];
    w = {fs, nl};
    mem.delete();
    nWrites = 0;
    pulseStart();
    sendWords(w, 2, 0);
    waitEnd();
    check("badErr", err, 1);
    check("badBusy", busy, 0);
    check("badDone", done, 0);
    check("badWrites", nWrites, 1);
    check("badAddr0", mem.exists(0) ? mem[0] : -1, fs);
  endtask
  initial begin
    int c[$], t[$], d[$], p[$], w[$];
    int fs, nl, tot, held;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    nomC = '{6, 6, 6};
    nomT = '{0, 1, 1};
    nomD = '{12, 12, 12, 12};
    for (int i = 0; i < 84; i++) nomP.push_back(i);
    repeat (3) @(negedge clk);
    check("rstWe", bus.ram_we, 0);
    check("rstAddr", bus.ram_addr, 0);
    check("rstData", bus.ram_wdata, 0);
    check("rstReady", bus.in_ready, 0);
    check("rstBusy", busy, 0);
    check("rstDone", done, 0);
    check("rstErr", err, 0);
    check("rstFoff", filter_offset, 0);
    check("rstDoff", dense_offset, 0);
    RST = 1'b1;
    runLoad(1, 3, nomC, nomT, nomD, nomP, 0);
    runLoad(1, 3, nomC, nomT, nomD, nomP, 1);
    runBad(5, 0);
    runLoad(1, 3, nomC, nomT, nomD, nomP, 0);
    runBad(7, 11);
    runLoad(1, 3, nomC, nomT, nomD, nomP, 2);
    p.delete();
    for (int i = 0; i < 40; i++) p.push_back($urandom_range(0, 65535));
    runLoad(3, 1, '{4}, '{0}, '{}, p, 0);
    runLoad(2, 2, '{0, 0}, '{1, 0}, '{0, 0}, '{}, 2);
    w = {1, 3};
    foreach (nomC[i]) w.push_back(nomC[i]);
    foreach (nomT[i]) w.push_back(nomT[i]);
    foreach (nomD[i]) w.push_back(nomD[i]);
    foreach (nomP[i]) w.push_back(nomP[i]);
    mem.delete();
    nWrites = 0;
    pulseStart();
    sendWords(w, 12 + 10, 0);
    check("abortWeBefore", bus.ram_we, 1);
    RST = 1'b0;
    #1;
    check("abortWe", bus.ram_we, 0);
    check("abortBusy", busy, 0);
    check("abortDone", done, 0);
    check("abortErr", err, 0);
    check("abortReady", bus.in_ready, 0);
    check("abortFoff", filter_offset, 0);
    check("abortDoff", dense_offset, 0);
`ifdef PAYLOAD_CHECKSUM_EN
    check("abortChecksum", checksum, 0);
`endif
    held = nWrites;
    repeat (3) @(negedge clk);
    check("abortWritesHeld", nWrites, held);
    check("abortWrites", nWrites, 12 + 2 + 9);
    RST = 1'b1;
    runLoad(1, 3, nomC, nomT, nomD, nomP, 1);
    repeat (6) begin
      c.delete();
      t.delete();
      d.delete();
      p.delete();
      fs = $urandom_range(1, 3);
      nl = $urandom_range(1, 4);
      tot = 0;
      for (int i = 0; i < nl; i++) begin
        c.push_back($urandom_range(0, 3));
        t.push_back($urandom_range(0, 1));
        tot += c[i] * (1 + fs * fs);
      end
      for (int i = 0; i < 2 * (nl - 1); i++) begin
        d.push_back($urandom_range(0, 4));
        tot += d[i];
      end
      for (int i = 0; i < tot; i++) p.push_back($urandom_range(0, 65535));
      runLoad(fs, nl, c, t, d, p, 2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
